// File: rtl/group_store_scheduler_if.sv
// Handshake bundle between the group store scheduler and its pixel source, grouper and frame-buffer port.
// GROUP_STORE_CHECKSUM_EN adds the frame checksum signal.
interface group_store_scheduler_if #(
   parameter int GROUP_SIZE = 16,
   parameter int ADDR_WIDTH = 9
);
   logic                  start;
   logic                  bitValid;
   logic                  bitIn;
   logic                  bitReady;
   logic                  grpEnable;
   logic                  grpElement;
   logic                  grpLoaded;
   logic [GROUP_SIZE-1:0] grpData;
   logic                  memWrite;
   logic [ADDR_WIDTH-1:0] memAddr;
   logic [GROUP_SIZE-1:0] memData;
   logic                  memAck;
   logic                  busy;
   logic                  done;
`ifdef GROUP_STORE_CHECKSUM_EN
   logic [GROUP_SIZE-1:0] checksum;

   modport master (
      input  start, bitValid, bitIn, grpLoaded, grpData, memAck,
      output bitReady, grpEnable, grpElement, memWrite, memAddr, memData, busy, done, checksum
   );
   modport slave (
      output start, bitValid, bitIn, grpLoaded, grpData, memAck,
      input  bitReady, grpEnable, grpElement, memWrite, memAddr, memData, busy, done, checksum
   );
`else
   modport master (
      input  start, bitValid, bitIn, grpLoaded, grpData, memAck,
      output bitReady, grpEnable, grpElement, memWrite, memAddr, memData, busy, done
   );
   modport slave (
      output start, bitValid, bitIn, grpLoaded, grpData, memAck,
      input  bitReady, grpEnable, grpElement, memWrite, memAddr, memData, busy, done
   );
`endif
endinterface

// File: rtl/group_store_scheduler.sv
// Feeds a pixel bit stream into a grouper and writes each finished group to a frame buffer.
// Optional XOR checksum of the written frame under GROUP_STORE_CHECKSUM_EN.
module group_store_scheduler #(
   parameter int GROUP_SIZE      = 16,
   parameter int WORDS_PER_FRAME = 300,
   parameter int ADDR_WIDTH      = 9,
   parameter int BASE_ADDR       = 0
) (
   input logic                     clock,
   input logic                     resetN,
   group_store_scheduler_if.master bus
);
   localparam int CNT_W = (GROUP_SIZE > 1) ? $clog2(GROUP_SIZE) : 1;
   localparam logic [CNT_W-1:0]      LAST_BIT   = CNT_W'(GROUP_SIZE - 1);
   localparam logic [ADDR_WIDTH-1:0] LAST_WORD  = ADDR_WIDTH'(WORDS_PER_FRAME - 1);
   localparam logic [ADDR_WIDTH-1:0] FIRST_ADDR = ADDR_WIDTH'(BASE_ADDR);

   typedef enum logic [2:0] {IDLE, FILL, WAIT_GRP, WRITE, DONE} state_t;

   state_t                state_reg, state_next;
   logic [CNT_W-1:0]      bit_cnt_reg;
   logic [ADDR_WIDTH-1:0] word_cnt_reg;
   logic [ADDR_WIDTH-1:0] mem_addr_reg;
   logic [GROUP_SIZE-1:0] mem_data_reg;
   logic                  accept;
   logic                  last_bit;
   logic                  last_word;

   assign accept    = (state_reg == FILL) && bus.bitValid;
   assign last_bit  = (bit_cnt_reg == LAST_BIT);
   assign last_word = (word_cnt_reg == LAST_WORD);

   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) state_reg <= IDLE;
      else         state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:     if (bus.start)           state_next = FILL;
         FILL:     if (accept && last_bit)  state_next = WAIT_GRP;
         WAIT_GRP: if (bus.grpLoaded)       state_next = WRITE;
         WRITE:    if (bus.memAck)          state_next = last_word ? DONE : FILL;
         DONE:                              state_next = IDLE;
         default:                           state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         bit_cnt_reg  <= '0;
         word_cnt_reg <= '0;
         mem_addr_reg <= '0;
         mem_data_reg <= '0;
      end else begin
         case (state_reg)
            IDLE: if (bus.start) begin
               bit_cnt_reg  <= '0;
               word_cnt_reg <= '0;
               mem_addr_reg <= FIRST_ADDR;
            end
            FILL: if (accept) bit_cnt_reg <= last_bit ? '0 : bit_cnt_reg + 1'b1;
            WAIT_GRP: if (bus.grpLoaded) mem_data_reg <= bus.grpData;
            // The final word leaves the address on the last location of the frame.
            WRITE: if (bus.memAck && !last_word) begin
               mem_addr_reg <= mem_addr_reg + 1'b1;
               word_cnt_reg <= word_cnt_reg + 1'b1;
            end
            default: ;
         endcase
      end
   end

`ifdef GROUP_STORE_CHECKSUM_EN
   logic [GROUP_SIZE-1:0] checksum_reg;

   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN)                                  checksum_reg <= '0;
      else if (state_reg == IDLE && bus.start)      checksum_reg <= '0;
      else if (state_reg == WRITE && bus.memAck)    checksum_reg <= checksum_reg ^ mem_data_reg;
   end

   assign bus.checksum = checksum_reg;
`endif

   assign bus.bitReady   = (state_reg == FILL);
   assign bus.grpEnable  = accept;
   // Gated by reset so every output reads 0 while reset is held.
   assign bus.grpElement = bus.bitIn & resetN;
   assign bus.memWrite   = (state_reg == WRITE);
   assign bus.memAddr    = mem_addr_reg;
   assign bus.memData    = mem_data_reg;
   assign bus.busy       = (state_reg != IDLE);
   assign bus.done       = (state_reg == DONE);
endmodule

// File: tb/tb_group_store_scheduler.sv
// Directed bench: full 300-word frames, async abort, stalls, and a one-word frame at base 20.
module tb_group_store_scheduler;
   logic clock = 1'b0;
   logic resetN;
   always #5 clock = ~clock;

   group_store_scheduler_if #(.GROUP_SIZE(16), .ADDR_WIDTH(9)) bus0 ();
   group_store_scheduler_if #(.GROUP_SIZE(16), .ADDR_WIDTH(9)) bus1 ();

   group_store_scheduler dut0 (.clock(clock), .resetN(resetN), .bus(bus0));
   group_store_scheduler #(.WORDS_PER_FRAME(1), .BASE_ADDR(20)) dut1 (.clock(clock), .resetN(resetN), .bus(bus1));

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] word_of(input int i);
      case (i)
         0:       word_of = 16'h00FF;
         1:       word_of = 16'h0F0F;
         2:       word_of = 16'h1234;
         default: word_of = {8'(i) ^ 8'h5A, ~8'(i)};
      endcase
   endfunction

   task automatic check_zero(input string p, input logic mw, input logic [8:0] a, input logic [15:0] d,
                             input logic b, input logic dn, input logic br, input logic ge, input logic gel);
      check({p, "_memWrite"}, mw, 0);
      check({p, "_memAddr"}, a, 0);
      check({p, "_memData"}, d, 0);
      check({p, "_busy"}, b, 0);
      check({p, "_done"}, dn, 0);
      check({p, "_bitReady"}, br, 0);
      check({p, "_grpEnable"}, ge, 0);
      check({p, "_grpElement"}, gel, 0);
   endtask

   // Drives one frame on dut0, acting as pixel source, grouper and RAM.
   task automatic run_frame(input bit toggle, input int stall_word, input int stall_len,
                            input int abort_word, output bit aborted);
      int widx = 0, wlen = 0, pulses = 0, sidx = 0, swrd = 0, gcnt = 0, hold;
      logic [15:0] sh = '0, csum = '0, w;
      bit pend = 0, seen_done = 0, ck3 = 0;
      aborted = 0;
      @(negedge clock) bus0.start = 1'b1;
      for (int cyc = 0; cyc < 20000; cyc++) begin
         @(negedge clock);
         if (cyc == 0) begin
            bus0.start = 1'b0;
            check("ready_after_start", bus0.bitReady, 1);
            check("busy_after_start", bus0.busy, 1);
         end
         if (seen_done) begin
            check("busy_after_done", bus0.busy, 0);
            check("done_one_cycle", bus0.done, 0);
            break;
         end
`ifdef GROUP_STORE_CHECKSUM_EN
         if (ck3) begin
            check("checksum_3words", bus0.checksum, 16'h1DC4);
            ck3 = 0;
         end
`endif
         hold = (widx == stall_word) ? stall_len : 0;
         if (widx == abort_word) hold = 1000000;
         if (bus0.memWrite) begin
            wlen++;
            check("write_addr", bus0.memAddr, widx);
            check("write_data", bus0.memData, word_of(widx));
            check("ready_in_write", bus0.bitReady, 0);
            if (widx == abort_word && wlen == 3) begin
               bus0.memAck = 1'b0;
               aborted = 1;
               return;
            end
            bus0.memAck = (wlen > hold);
         end else begin
            bus0.memAck = (cyc % 2 == 1);  // stray acks outside WRITE
         end
         if (bus0.done) begin
            check("writes_at_done", widx, 300);
            check("busy_at_done", bus0.busy, 1);
            seen_done = 1;
`ifdef GROUP_STORE_CHECKSUM_EN
            check("checksum_at_done", bus0.checksum, csum);
`endif
         end
         if (pend) check("ready_in_wait", bus0.bitReady, 0);
         bus0.grpLoaded = pend ? 1'b1 : (cyc % 3 == 0);
         bus0.grpData   = pend ? sh : 16'hDEAD;
         pend = 0;
         w = word_of(swrd);
         bus0.bitValid = toggle ? (cyc % 2 == 1) : 1'b1;
         bus0.bitIn    = w[15 - sidx];
         #1;
         check("grp_enable", bus0.grpEnable, bus0.bitValid && bus0.bitReady);
         check("grp_element", bus0.grpElement, bus0.bitIn);
         if (bus0.grpEnable) begin
            sh = {sh[14:0], bus0.grpElement};
            pulses++;
            gcnt++;
            sidx++;
            if (sidx == 16) begin sidx = 0; swrd++; end
            if (gcnt == 16) begin gcnt = 0; pend = 1; end
         end
         if (bus0.memWrite && bus0.memAck) begin
            check("write_len", wlen, hold + 1);
            check("pulses_per_word", pulses, 16);
            csum ^= word_of(widx);
            widx++;
            wlen = 0;
            pulses = 0;
            if (widx == 3) ck3 = 1;
         end
      end
      check("frame_completed", seen_done, 1);
      bus0.memAck = 1'b0;
      bus0.grpLoaded = 1'b0;
   endtask

   initial begin
      bit ab;
      logic [15:0] w1, sh1;
      resetN = 1'b0;
      bus0.start = 0; bus0.bitValid = 1; bus0.bitIn = 1; bus0.grpLoaded = 0; bus0.grpData = '0; bus0.memAck = 0;
      bus1.start = 0; bus1.bitValid = 1; bus1.bitIn = 1; bus1.grpLoaded = 0; bus1.grpData = '0; bus1.memAck = 0;
      repeat (2) @(negedge clock);
      check_zero("rst0", bus0.memWrite, bus0.memAddr, bus0.memData, bus0.busy, bus0.done,
                 bus0.bitReady, bus0.grpEnable, bus0.grpElement);
      check_zero("rst1", bus1.memWrite, bus1.memAddr, bus1.memData, bus1.busy, bus1.done,
                 bus1.bitReady, bus1.grpEnable, bus1.grpElement);
      resetN = 1'b1;
      bus1.bitValid = 0;

      // Abort while word 3 is waiting for its ack; reset must act before the next edge.
      run_frame(0, -1, 0, 3, ab);
      check("abort_reached", ab, 1);
      bus0.bitValid = 1; bus0.bitIn = 1;
      #2 resetN = 1'b0;
      #1 check_zero("async", bus0.memWrite, bus0.memAddr, bus0.memData, bus0.busy, bus0.done,
                    bus0.bitReady, bus0.grpEnable, bus0.grpElement);
      @(negedge clock);
      @(negedge clock) resetN = 1'b1;
      bus0.bitValid = 0;
      repeat (3) begin
         @(negedge clock);
         check("no_write_after_abort", bus0.memWrite, 0);
         check("idle_after_abort", bus0.busy, 0);
      end

      run_frame(0, -1, 0, -1, ab);
      run_frame(1, 7, 5, -1, ab);

      // One-word frame at base 20, with a stray start while busy.
      w1 = 16'hA5C3;
      sh1 = '0;
      @(negedge clock) bus1.start = 1'b1;
      @(negedge clock);
      bus1.start = 1'b0;
      check("w1_busy", bus1.busy, 1);
      for (int i = 0; i < 16; i++) begin
         bus1.bitValid = 1'b1;
         bus1.bitIn = w1[15 - i];
         bus1.start = (i == 5);
         #1 check("w1_enable", bus1.grpEnable, 1);
         sh1 = {sh1[14:0], bus1.grpElement};
         @(negedge clock);
      end
      bus1.start = 1'b0;
      #1;
      check("w1_ready_wait", bus1.bitReady, 0);
      check("w1_enable_wait", bus1.grpEnable, 0);
      bus1.grpLoaded = 1'b1;
      bus1.grpData = sh1;
      @(negedge clock);
      bus1.grpLoaded = 1'b0;
      check("w1_memWrite", bus1.memWrite, 1);
      check("w1_addr", bus1.memAddr, 20);
      check("w1_data", bus1.memData, 16'hA5C3);
      bus1.memAck = 1'b1;
      @(negedge clock);
      bus1.memAck = 1'b0;
      check("w1_done", bus1.done, 1);
      check("w1_write_ended", bus1.memWrite, 0);
      check("w1_addr_hold", bus1.memAddr, 20);
`ifdef GROUP_STORE_CHECKSUM_EN
      check("w1_checksum", bus1.checksum, 16'hA5C3);
`endif
      @(negedge clock);
      bus1.bitValid = 1'b0;
      check("w1_done_pulse", bus1.done, 0);
      check("w1_idle", bus1.busy, 0);
      repeat (3) begin
         @(negedge clock);
         check("w1_start_ignored", bus1.busy, 0);
         check("w1_no_extra_write", bus1.memWrite, 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
